// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and queue entry type for instruction fetch
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - parameterized synchronous FIFO with clear and occupancy count
module fetch_fifo #(
  parameter type DATA_T = logic [31:0],
  parameter int  DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  DATA_T         din,
  output DATA_T         dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  DATA_T         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read out until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && full && !do_pop));
  underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clear && empty));
endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - sequential instruction prefetch with credit-limited issue and redirect flush
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int         CW  = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   occ, outstanding, drop;
  logic [CW:0]     inflight;
  logic            req_fire, rsp_keep, q_pop;
  logic            q_empty, q_full, tag_empty, tag_full;
  fetch_entry_t    q_head, q_din;
  logic            unused_ok;

  // Queued plus in-flight entries never exceed DEPTH, so a response always has a slot.
  assign inflight      = {1'b0, occ} + {1'b0, outstanding};
  assign mem_req_valid = reset & ~redirect & (inflight < CAP);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid & mem_req_ready;

  assign rsp_keep = mem_rsp_valid & ~redirect & (drop == '0);
  assign q_pop    = instr_valid & instr_ready & ~redirect;
  assign q_din    = '{instr: mem_rsp_data, pc: rsp_pc};

  assign instr_valid = ~q_empty;
  assign instr       = q_empty ? '0 : q_head.instr;
  assign instr_pc    = q_empty ? '0 : q_head.pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop     <= outstanding - CW'(mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (mem_rsp_valid && drop != '0) drop <= drop - CW'(1);
    end
  end

  fetch_fifo #(.DATA_T(fetch_entry_t), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .rst_n (reset),
    .push  (rsp_keep),
    .pop   (q_pop),
    .clear (redirect),
    .din   (q_din),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (occ)
  );

  // Tag FIFO occupancy is the outstanding-request count; dropped tags drain in order.
  fetch_fifo #(.DATA_T(logic [XLEN-1:0]), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst_n (reset),
    .push  (req_fire),
    .pop   (mem_rsp_valid),
    .clear (1'b0),
    .din   (fetch_pc),
    .dout  (rsp_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  assign unused_ok = &{1'b0, redirect_pc[1:0], q_full, tag_full, tag_empty};
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - randomized scoreboard bench for the prefetch queue
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_rsp_data;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc, redirect_pc;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  always #10 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] addr; int due; }   mreq_t;

  int           n_cmp = 0, n_bad = 0;
  fetch_entry_t exp_q[$];
  out_t         out_q[$];
  mreq_t        mem_q[$];
  logic [31:0]  model_pc = RESET_PC;
  bit           active = 1'b0;
  int           cyc = 0, last_due = 0;
  int           lat_min, lat_max, p_mready, p_iready, p_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp_v);
    end
  endtask

  task automatic step();
    bit          rsp, fire, redir;
    logic [31:0] rpc;
    mreq_t       m;
    out_t        o;
    int          due;
    @(negedge clk);
    cyc++;
    rsp = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m   = mem_q.pop_front();
      rsp = 1'b1;
    end
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? mem_word(m.addr) : $urandom;
    mem_req_ready = ($urandom_range(99) < p_mready);
    instr_ready   = ($urandom_range(99) < p_iready);
    redir         = ($urandom_range(99) < p_redir);
    rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(3)))
                                   : ($urandom & 32'h0000_0FFF);
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    check("mem_req_valid", 32'(mem_req_valid),
          32'((exp_q.size() + out_q.size() < DEPTH) && !redir));
    if (mem_req_valid) check("mem_req_addr", mem_req_addr, model_pc);
    fire = mem_req_valid && mem_req_ready;
    #2;
    // Reference update for the coming edge; the monitor has already seen this cycle.
    if (rsp) begin
      o = out_q.pop_front();
      if (!o.stale && !redir) exp_q.push_back('{instr: mem_word(o.addr), pc: o.addr});
    end
    if (redir) begin
      exp_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      model_pc = {rpc[31:2], 2'b00};
    end else if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      out_q.push_back('{addr: model_pc, stale: 1'b0});
      mem_q.push_back('{addr: mem_req_addr, due: due});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int hold);
    active = 1'b0;
    @(negedge clk);
    #5;
    reset = 1'b0;
    #1;
    check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst mem_req_addr", mem_req_addr, RESET_PC);
    check("rst instr_valid", 32'(instr_valid), 32'd0);
    check("rst instr", instr, 32'd0);
    check("rst instr_pc", instr_pc, 32'd0);
    mem_q.delete();
    out_q.delete();
    exp_q.delete();
    model_pc      = RESET_PC;
    last_due      = 0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    repeat (hold) @(posedge clk);
    #2;
    reset  = 1'b1;
    active = 1'b1;
  endtask

  task automatic knobs(input int lmin, input int lmax, input int pm, input int pi, input int pr);
    lat_min = lmin; lat_max = lmax; p_mready = pm; p_iready = pi; p_redir = pr;
  endtask

  // Monitor: compares the DUT head against the scoreboard whenever it is presented.
  always @(negedge clk) begin
    #2;
    if (active) begin
      check("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
      if (instr_valid && exp_q.size() > 0) begin
        check("instr_pc", instr_pc, exp_q[0].pc);
        check("instr", instr, exp_q[0].instr);
        if (instr_ready && !redirect) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    knobs(1, 1, 100, 100, 0);
    do_reset(2);
    run(20);

    knobs(3, 3, 100, 0, 0);
    do_reset(2);
    run(16);

    knobs(1, 4, 70, 60, 8);
    run(400);

    knobs(1, 3, 50, 80, 5);
    run(37);
    do_reset(3);
    run(300);

    for (int k = 0; k < 6; k++) begin
      knobs(1, 1 + $urandom_range(4), 30 + $urandom_range(70),
            $urandom_range(100), $urandom_range(20));
      run(100 + $urandom_range(300));
      do_reset(1 + $urandom_range(3));
    end
    knobs(1, 2, 100, 100, 3);
    run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch queue between the instruction-memory bus and the IF stage of the pipelined RV32I core. It issues sequential word fetches to a latency-tolerant memory port, buffers returned instructions with their PCs, and presents them to IF through a valid/ready handshake. Branch redirects from EX flush the queue and discard in-flight responses.

## Interface
- DEPTH, 4: queue entries; also the cap on entries plus outstanding requests; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  word-aligned fetch address
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_rsp_valid  in  1  response data valid; responses return in request order, any latency ≥1
- mem_rsp_data  in  32  instruction word
- instr_valid  out  1  queue head valid toward IF
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- instr_ready  in  1  IF consumes head (driven low by IF during stall)
- redirect  in  1  branch taken in EX; flush and restart
- redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced to 0)

## Operation
- State: fetch_pc, queue (instr, pc) of DEPTH entries, occ count, outstanding count, drop count; counters are $clog2(DEPTH+1) bits.
- Issue: mem_req_valid = (occ + outstanding < DEPTH) & ~redirect. On valid & ready: outstanding +1; fetch_pc += 4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Each request is tagged with its address through a DEPTH-deep in-order address FIFO, so the response is written with its own PC.
- Response: on mem_rsp_valid, outstanding −1. If drop > 0, the response is discarded and drop −1. Otherwise it is pushed into the queue.
- The credit rule guarantees the queue can never overflow. Overflow, underflow, and mem_rsp_valid with outstanding = 0 are assertion errors.
- Pop: instr_valid & instr_ready removes the head. Push and pop in the same cycle leave occ unchanged.
- Redirect, which has priority over all other events in its cycle:
  - Queue is cleared (occ = 0); any pop that cycle is ignored.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - drop ← outstanding − mem_rsp_valid; a response arriving that same cycle is discarded.
  - No request is issued that cycle.
  - Address FIFO entries of dropped requests are consumed normally.
- Back-to-back redirects: each reloads fetch_pc and recomputes drop from the current outstanding count. Requests issued after the last redirect are never dropped.

## Timing
- Reset values:
  - mem_req_valid = 0, mem_req_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0.
  - fetch_pc = RESET_PC; occ, outstanding and drop = 0.
- First request: mem_req_valid asserts combinationally in the first cycle after reset deasserts.
- Reset asserted mid-operation returns to the reset state immediately. The memory side must likewise abandon in-flight responses.
- Response-to-IF latency: 1 cycle. A response in cycle N makes instr_valid high in N+1 at the earliest; there is no combinational bypass.
- Credits update on the edge. A pop in cycle N frees a request slot in cycle N+1.
- mem_req_addr, instr and instr_pc hold stable while their valid is high and the handshake has not completed.
- Steady state with a 1-cycle memory and instr_ready = 1: one instruction per cycle once the queue is primed.
- Combinational paths: redirect → mem_req_valid only; no path from instr_ready to mem_req_valid.

## Structure
- Shared package fetch_pkg:
  - XLEN = 32
  - INSTR_BYTES = 4
  - fetch_entry_t struct {instr, pc}
  - NOP_INSTR = 32'h0000_0013
- Sub-module fetch_fifo: a parameterized synchronous FIFO (DATA_T, DEPTH) with push, pop, clear, full, empty and count. Two instances are used: the instruction queue and the address tag FIFO.
- The top holds the counters, the issue logic and the drop logic.

## Test plan
- Reset release, 1-cycle memory, instr_ready = 1 → requests at 0x0, 0x4, 0x8; instr_pc sequence 0x0, 0x4, 0x8 on consecutive cycles from cycle 2.
- instr_ready = 0 held, 3-cycle memory, DEPTH = 4 → exactly 4 requests issued, mem_req_valid low thereafter, instr_pc = 0x0 held stable.
- Two requests outstanding, redirect to 0x100 → both returning responses dropped; next instr_pc = 0x100, then 0x104.
- Redirect in the same cycle as mem_rsp_valid and instr_ready → that response and the pop are discarded, drop = outstanding − 1, occ = 0 next cycle.
- redirect_pc = 0xFFFF_FFF8 → fetched PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- mem_req_ready toggling randomly and reset asserted mid-burst → all outputs at reset values asynchronously; fetch restarts at RESET_PC; no assertion fires.
